qr_grid_sampler: RTL and testbench

QR_GRID_SAMPLER -- requirements
Module: qr_grid_sampler

---
 rtl/qr_grid_sampler.sv | 247 ++++++++++++++++++++++++
 tb/tb_qr_grid_sampler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qr_grid_sampler.sv
// qr_grid_sampler: walks a QR module grid anchored on the top-left finder centre, reads one
// binarized frame-buffer pixel per module (2-cycle read latency) and streams out module bits.
// Build option: define QR_MAJORITY_SAMPLE_EN to take a 3-tap horizontal majority per module
// (x-1, x, x+1) instead of a single centre sample.
module qr_grid_sampler #(
   parameter int unsigned MODULES = 21,
   parameter int unsigned HRES    = 320,
   parameter int unsigned VRES    = 240
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic [2:0][8:0] centers_x,
   input  logic [2:0][8:0] centers_y,
   input  logic [8:0]      mod_size,
   input  logic            mod_size_valid,
   output logic [16:0]     pixel_addr,
   input  logic            pixel_in,
   output logic            bit_out,
   output logic [8:0]      bit_addr,
   output logic            bit_valid,
   output logic            busy,
   output logic            done,
   output logic            oob_err
);

   // Running coordinates are kept wider than the 12-bit origin so col*mod_size cannot wrap.
   localparam int          CW   = 16;
   localparam int unsigned NMOD = MODULES * MODULES;
`ifdef QR_MAJORITY_SAMPLE_EN
   localparam int unsigned DRAIN_LEN = 4;
`else
   localparam int unsigned DRAIN_LEN = 2;
`endif
   localparam logic signed [CW-1:0] HRES_S = CW'(HRES);
   localparam logic signed [CW-1:0] VRES_S = CW'(VRES);

   typedef enum logic [1:0] {StIdle, StOrigin, StIssue, StDrain} state_t;

   state_t               state_q, state_d;
   logic [2:0][8:0]      cx_q, cy_q;
   logic [8:0]           ms_q;
   logic signed [CW-1:0] ox_q, x_q, y_q;
   logic [8:0]           col_q, k_q;
   logic [2:0]           drain_q;
   logic                 oob_q, done_q;
   logic                 v1_q, v2_q, o1_q, o2_q;
   logic [8:0]           a1_q, a2_q;
`ifdef QR_MAJORITY_SAMPLE_EN
   logic [1:0]           sub_q, s1_q, s2_q;
   logic                 m0_q, m1_q;
`endif

   logic                 accept, zero_start, drain_end, issuing, mod_step, last_step;
   logic                 in_frame, pix_ok;
   logic [9:0]           sum0, sum1, sum2, best;
   logic [8:0]           cx_sel, cy_sel;
   logic signed [CW-1:0] sx, ms_ext, ms3, ox_c, oy_c;

   // Pick the top-left finder (smallest x+y, ties to lowest index) and derive the grid origin.
   always_comb begin
      sum0   = {1'b0, cx_q[0]} + {1'b0, cy_q[0]};
      sum1   = {1'b0, cx_q[1]} + {1'b0, cy_q[1]};
      sum2   = {1'b0, cx_q[2]} + {1'b0, cy_q[2]};
      best   = sum0;
      cx_sel = cx_q[0];
      cy_sel = cy_q[0];
      if (sum1 < best) begin
         best   = sum1;
         cx_sel = cx_q[1];
         cy_sel = cy_q[1];
      end
      if (sum2 < best) begin
         best   = sum2;
         cx_sel = cx_q[2];
         cy_sel = cy_q[2];
      end
      ms_ext = $signed({7'b0, ms_q});
      ms3    = ms_ext + $signed({6'b0, ms_q, 1'b0});
      ox_c   = $signed({7'b0, cx_sel}) - ms3;
      oy_c   = $signed({7'b0, cy_sel}) - ms3;
   end

   // Current sample point, frame bounds test and frame-buffer address.
   always_comb begin
      issuing = (state_q == StIssue);
      sx      = x_q;
`ifdef QR_MAJORITY_SAMPLE_EN
      case (sub_q)
         2'd0:    sx = x_q - $signed(CW'(1));
         2'd2:    sx = x_q + $signed(CW'(1));
         default: sx = x_q;
      endcase
      mod_step = issuing && (sub_q == 2'd2);
`else
      mod_step = issuing;
`endif
      last_step  = mod_step && (k_q == 9'(NMOD - 1));
      in_frame   = !sx[CW-1] && (sx < HRES_S) && !y_q[CW-1] && (y_q < VRES_S);
      pixel_addr = (issuing && in_frame) ? 17'(y_q) * 17'(HRES) + 17'(sx) : 17'd0;
   end

   // Next-state logic for the sampling sequence.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      zero_start = 1'b0;
      drain_end  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mod_size_valid) begin
               if (mod_size != 9'd0) begin
                  accept  = 1'b1;
                  state_d = StOrigin;
               end else begin
                  zero_start = 1'b1;
               end
            end
         end
         StOrigin: state_d = StIssue;
         StIssue:  if (last_step) state_d = StDrain;
         StDrain: begin
            if (drain_q == 3'(DRAIN_LEN - 1)) begin
               drain_end = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Latched request, running grid walk, drain counter and status flags.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cx_q    <= '0;
         cy_q    <= '0;
         ms_q    <= '0;
         ox_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         col_q   <= '0;
         k_q     <= '0;
         drain_q <= '0;
         oob_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q  <= zero_start || drain_end;
         drain_q <= (state_q == StDrain) ? drain_q + 3'd1 : 3'd0;
         if (accept) begin
            cx_q  <= centers_x;
            cy_q  <= centers_y;
            ms_q  <= mod_size;
            oob_q <= 1'b0;
         end
         if (zero_start || (issuing && !in_frame)) oob_q <= 1'b1;
         if (state_q == StOrigin) begin
            ox_q  <= ox_c;
            x_q   <= ox_c;
            y_q   <= oy_c;
            col_q <= '0;
            k_q   <= '0;
         end
         if (mod_step) begin
            k_q <= k_q + 9'd1;
            if (col_q == 9'(MODULES - 1)) begin
               col_q <= '0;
               x_q   <= ox_q;
               y_q   <= y_q + ms_ext;
            end else begin
               col_q <= col_q + 9'd1;
               x_q   <= x_q + ms_ext;
            end
         end
      end
   end

`ifdef QR_MAJORITY_SAMPLE_EN
   // Tap counter within a module and capture of the first two taps for the vote.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sub_q <= '0;
         m0_q  <= 1'b0;
         m1_q  <= 1'b0;
      end else begin
         if (state_q == StOrigin) sub_q <= '0;
         else if (issuing)        sub_q <= (sub_q == 2'd2) ? 2'd0 : sub_q + 2'd1;
         if (v2_q && s2_q == 2'd0) m0_q <= pix_ok;
         if (v2_q && s2_q == 2'd1) m1_q <= pix_ok;
      end
   end
`endif

   // Two-stage tag pipeline matching the frame-buffer read latency.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         o1_q <= 1'b0;
         o2_q <= 1'b0;
         a1_q <= '0;
         a2_q <= '0;
`ifdef QR_MAJORITY_SAMPLE_EN
         s1_q <= '0;
         s2_q <= '0;
`endif
      end else begin
         v1_q <= issuing;
         v2_q <= v1_q;
         if (issuing) begin
            a1_q <= k_q;
            o1_q <= !in_frame;
`ifdef QR_MAJORITY_SAMPLE_EN
            s1_q <= sub_q;
`endif
         end
         if (v1_q) begin
            a2_q <= a1_q;
            o2_q <= o1_q;
`ifdef QR_MAJORITY_SAMPLE_EN
            s2_q <= s1_q;
`endif
         end
      end
   end

   // Output bit: out-of-frame taps read as light.
   always_comb begin
      pix_ok = pixel_in & ~o2_q;
`ifdef QR_MAJORITY_SAMPLE_EN
      bit_valid = v2_q && (s2_q == 2'd2);
      bit_out   = bit_valid & ((m0_q & m1_q) | (m0_q & pix_ok) | (m1_q & pix_ok));
`else
      bit_valid = v2_q;
      bit_out   = v2_q & pix_ok;
`endif
      bit_addr = a2_q;
      busy     = (state_q != StIdle);
      done     = done_q;
      oob_err  = oob_q;
   end

endmodule

// File: tb/tb_qr_grid_sampler.sv
// Bench for qr_grid_sampler: frame-buffer model with 2-cycle read latency, table of grid
// geometries with hand-derived origins/addresses, and a scoreboard of expected module bits.
module tb_qr_grid_sampler;
   localparam int MODULES = 21;
   localparam int HRES    = 320;
   localparam int VRES    = 240;
   localparam int NMOD    = MODULES * MODULES;
`ifdef QR_MAJORITY_SAMPLE_EN
   localparam int RD  = 3;
   localparam int LAT = 4;
`else
   localparam int RD  = 1;
   localparam int LAT = 2;
`endif

   typedef struct packed {
      logic [2:0][8:0] cx;
      logic [2:0][8:0] cy;
      logic [8:0]      ms;
      int              ox;
      int              oy;
      logic            oob;
      logic            dark;
      int              first_a;
      int              last_a;
   } vec_t;

   typedef struct packed {
      int   t;
      int   a;
      logic b;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_in = 1'b1;
   logic [2:0][8:0] centers_x = '0;
   logic [2:0][8:0] centers_y = '0;
   logic [8:0]      mod_size = '0;
   logic            mod_size_valid = 1'b0;
   logic [16:0]     pixel_addr;
   logic            pixel_in;
   logic            bit_out;
   logic [8:0]      bit_addr;
   logic            bit_valid, busy, done, oob_err;
   logic            r1 = 1'b0, r2 = 1'b0;

   int   checks = 0;
   int   passed = 0;
   int   g_ox = 0, g_oy = 0, g_ms = 8;
   logic g_dark = 1'b0;
   vec_t vecs[5];

   always #5 clk = ~clk;

   qr_grid_sampler #(.MODULES(MODULES), .HRES(HRES), .VRES(VRES)) dut (
      .clk_in        (clk),
      .rst_in        (rst_in),
      .centers_x     (centers_x),
      .centers_y     (centers_y),
      .mod_size      (mod_size),
      .mod_size_valid(mod_size_valid),
      .pixel_addr    (pixel_addr),
      .pixel_in      (pixel_in),
      .bit_out       (bit_out),
      .bit_addr      (bit_addr),
      .bit_valid     (bit_valid),
      .busy          (busy),
      .done          (done),
      .oob_err       (oob_err)
   );

   // Frame content: all dark, or a checkerboard aligned to the current module grid.
   function automatic logic px(int x, int y);
      int dx, dy;
      if (x < 0 || x >= HRES || y < 0 || y >= VRES) return 1'b0;
      if (g_dark) return 1'b1;
      if (g_ms == 0) return 1'b0;
      dx = x - g_ox + g_ms / 2;
      dy = y - g_oy + g_ms / 2;
      if (dx < 0 || dy < 0) return 1'b0;
      return ((dx / g_ms + dy / g_ms) % 2) == 1;
   endfunction

   // Frame buffer with two register stages of read latency.
   always @(posedge clk) begin
      r1 <= px(int'(pixel_addr) % HRES, int'(pixel_addr) / HRES);
      r2 <= r1;
   end
   assign pixel_in = r2;

   task automatic chk(input string name, input int idx, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s[%0d]: got %0d, want %0d", name, idx, act, exp);
   endtask

   function automatic vec_t mk(int x0, int x1, int x2, int y0, int y1, int y2, int ms,
                               int ox, int oy, int oob, int dark, int fa, int la);
      vec_t v;
      v.cx[0]   = 9'(x0);
      v.cx[1]   = 9'(x1);
      v.cx[2]   = 9'(x2);
      v.cy[0]   = 9'(y0);
      v.cy[1]   = 9'(y1);
      v.cy[2]   = 9'(y2);
      v.ms      = 9'(ms);
      v.ox      = ox;
      v.oy      = oy;
      v.oob     = (oob != 0);
      v.dark    = (dark != 0);
      v.first_a = fa;
      v.last_a  = la;
      return v;
   endfunction

   task automatic check_reset_outputs(input int idx);
      chk("rst_pixel_addr", idx, pixel_addr, 0);
      chk("rst_bit_out", idx, bit_out, 0);
      chk("rst_bit_addr", idx, bit_addr, 0);
      chk("rst_bit_valid", idx, bit_valid, 0);
      chk("rst_busy", idx, busy, 0);
      chk("rst_done", idx, done, 0);
      chk("rst_oob_err", idx, oob_err, 0);
   endtask

   // Run one grid from table entry idx; optionally re-pulse start or reset mid-run at cycle t.
   task automatic run_grid(input int idx, input int repulse_t, input int reset_t);
      vec_t v;
      exp_t sb[$];
      exp_t e;
      int   ea[$];
      int   done_t, x, y, xs, ones, post;
      logic inf, bexp, seen_done;
      v = vecs[idx];
      g_ox   = v.ox;
      g_oy   = v.oy;
      g_ms   = int'(v.ms);
      g_dark = v.dark;
      for (int k = 0; k < NMOD; k++) begin
         x    = v.ox + (k % MODULES) * int'(v.ms);
         y    = v.oy + (k / MODULES) * int'(v.ms);
         ones = 0;
         for (int r = 0; r < RD; r++) begin
            xs  = x + r - RD / 2;
            inf = (xs >= 0 && xs < HRES && y >= 0 && y < VRES);
            ea.push_back(inf ? y * HRES + xs : 0);
            if (inf && px(xs, y)) ones++;
         end
         bexp = (2 * ones > RD);
         sb.push_back('{t: RD * k + LAT, a: k, b: bexp});
      end
      done_t = RD * NMOD + LAT;

      @(negedge clk);
      centers_x      = v.cx;
      centers_y      = v.cy;
      mod_size       = v.ms;
      mod_size_valid = 1'b1;
      @(negedge clk);
      // Scramble inputs: the run must use the latched request.
      mod_size_valid = 1'b0;
      centers_x      = '1;
      centers_y      = '1;
      mod_size       = 9'd3;
      chk("busy_origin", idx, busy, 1);
      chk("oob_cleared_at_start", idx, oob_err, 0);

      seen_done = 1'b0;
      for (int t = 0; t <= done_t + 4 && !seen_done; t++) begin
         @(negedge clk);
         if (t < RD * NMOD) chk("pixel_addr", t, pixel_addr, ea[t]);
         if (t == RD / 2) chk("first_centre_addr", idx, pixel_addr, v.first_a);
         if (t == RD * NMOD - 1 - RD / 2) chk("last_centre_addr", idx, pixel_addr, v.last_a);
         if (bit_valid) begin
            if (sb.size() == 0) begin
               chk("extra_bit_valid", t, 1, 0);
            end else begin
               e = sb.pop_front();
               chk("bit_time", e.a, t, e.t);
               chk("bit_addr", e.a, bit_addr, e.a);
               chk("bit_out", e.a, bit_out, e.b);
            end
         end
         if (t == done_t - 1) chk("busy_before_done", idx, busy, 1);
         if (done) begin
            chk("done_time", idx, t, done_t);
            chk("busy_at_done", idx, busy, 0);
            seen_done = 1'b1;
         end
         if (t == repulse_t) begin
            centers_x      = vecs[3].cx;
            centers_y      = vecs[3].cy;
            mod_size       = vecs[3].ms;
            mod_size_valid = 1'b1;
         end else begin
            mod_size_valid = 1'b0;
         end
         if (t == reset_t) begin
            rst_in = 1'b1;
            @(negedge clk);
            check_reset_outputs(idx);
            rst_in = 1'b0;
            post   = 0;
            repeat (8) begin
               @(negedge clk);
               if (bit_valid || busy || done) post++;
            end
            chk("post_reset_activity", idx, post, 0);
            return;
         end
      end
      chk("done_seen", idx, seen_done, 1);
      chk("bits_left", idx, sb.size(), 0);
      chk("oob_err_final", idx, oob_err, v.oob);
      @(negedge clk);
      chk("done_one_cycle", idx, done, 0);
   endtask

   initial begin
      int quiet;
      //             centers_x      centers_y      ms  ox   oy  oob dark first  last
      vecs[0] = mk(30, 142, 30,   30, 30, 142,   8,   6,   6, 0, 0, 1926,  53286);
      vecs[1] = mk(142, 30, 30,   30, 142, 30,   8,   6,   6, 0, 0, 1926,  53286);
      vecs[2] = mk(10, 122, 10,   10, 10, 122,   8, -14, -14, 1, 1, 0,     46866);
      vecs[3] = mk(50, 20, 100,   20, 50, 100,   5,  35,   5, 0, 0, 1635,  33735);
      vecs[4] = mk(250, 330, 250, 180, 180, 260, 4, 238, 168, 1, 0, 53998, 0);

      repeat (3) @(negedge clk);
      check_reset_outputs(-1);
      rst_in = 1'b0;
      @(negedge clk);
      chk("idle_busy", 0, busy, 0);

      for (int i = 0; i < 5; i++) run_grid(i, -1, -1);

      // Start re-pulsed mid-grid with a different geometry must be ignored.
      run_grid(0, 50, -1);
      // Reset at module 100, then a clean full run.
      run_grid(0, -1, RD * 100);
      run_grid(0, -1, -1);

      // Zero module pitch: immediate done with error, no reads.
      @(negedge clk);
      centers_x      = vecs[0].cx;
      centers_y      = vecs[0].cy;
      mod_size       = 9'd0;
      mod_size_valid = 1'b1;
      @(negedge clk);
      mod_size_valid = 1'b0;
      chk("zero_done", 0, done, 1);
      chk("zero_oob", 0, oob_err, 1);
      chk("zero_busy", 0, busy, 0);
      chk("zero_pixel_addr", 0, pixel_addr, 0);
      quiet = 0;
      repeat (6) begin
         @(negedge clk);
         if (bit_valid || busy || done) quiet++;
      end
      chk("zero_quiet", 0, quiet, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
